// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Brief    : Round-robin arbiter that shares the register file write port among
//            ALU, load and mul/div requesters through a registered write slot.
// Revision : 1.0
// ============================================================================
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              req_valid,
    input  logic [3*ADDR_WIDTH-1:0] req_address,
    input  logic [3*DATA_WIDTH-1:0] req_data,
    output logic [2:0]              req_ready,
    output logic                    rf_write_enable,
    output logic [ADDR_WIDTH-1:0]   rf_write_address,
    output logic [DATA_WIDTH-1:0]   rf_write_data,
    output logic [1:0]              grant_id,
    output logic [CNT_WIDTH-1:0]    contention_count
);

    function automatic logic [1:0] rr_idx(input logic [1:0] p, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, p} + {1'b0, k};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    logic [1:0]            ptr_q, ptr_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            gid_q, gid_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic [1:0]            w_ptr;
    logic [2:0]            w_ready;
    logic [1:0]            w_winner;
    logic                  w_found;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_contended;

    // The encoding 3 is unreachable; fold it onto requester 0.
    assign w_ptr = (ptr_q == 2'd3) ? 2'd0 : ptr_q;

    always_comb begin
        w_ready  = 3'b000;
        w_winner = 2'd0;
        w_found  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!w_found && req_valid[rr_idx(w_ptr, 2'(k))]) begin
                w_found  = 1'b1;
                w_winner = rr_idx(w_ptr, 2'(k));
            end
        end
        if (reset) w_found = 1'b0;
        if (w_found) w_ready[w_winner] = 1'b1;
    end

    always_comb begin
        case (w_winner)
            2'd1:    begin
                w_sel_addr = req_address[ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_data = req_data[DATA_WIDTH +: DATA_WIDTH];
            end
            2'd2:    begin
                w_sel_addr = req_address[2*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_data = req_data[2*DATA_WIDTH +: DATA_WIDTH];
            end
            default: begin
                w_sel_addr = req_address[0 +: ADDR_WIDTH];
                w_sel_data = req_data[0 +: DATA_WIDTH];
            end
        endcase
    end

    assign w_contended = (req_valid[0] & req_valid[1]) |
                         (req_valid[0] & req_valid[2]) |
                         (req_valid[1] & req_valid[2]);

    always_comb begin
        ptr_d  = w_ptr;
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        gid_d  = gid_q;
        cnt_d  = cnt_q;
        if (w_found) begin
            ptr_d  = (w_winner == 2'd2) ? 2'd0 : w_winner + 2'd1;
            // Address 0 is hard-wired zero: accept the request but drop the write.
            we_d   = (w_sel_addr != '0);
            addr_d = w_sel_addr;
            data_d = w_sel_data;
            gid_d  = w_winner;
        end
        if (w_contended && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q  <= 2'd0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            gid_q  <= 2'd0;
            cnt_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            gid_q  <= gid_d;
            cnt_q  <= cnt_d;
        end
    end

    assign req_ready        = w_ready;
    assign rf_write_enable  = we_q;
    assign rf_write_address = addr_q;
    assign rf_write_data    = data_q;
    assign grant_id         = gid_q;
    assign contention_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Brief    : Directed-vector bench for regfile_write_arbiter (default and 4-bit counter builds).
// Revision : 1.0
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    req_valid;
    logic [3*AW-1:0] req_address;
    logic [3*DW-1:0] req_data;

    logic [2:0]    ready_a, ready_b;
    logic          we_a, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] data_a, data_b;
    logic [1:0]    gid_a, gid_b;
    logic [15:0]   cnt_a;
    logic [3:0]    cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(16)) u_dut_a (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_address(req_address),
        .req_data(req_data), .req_ready(ready_a), .rf_write_enable(we_a),
        .rf_write_address(addr_a), .rf_write_data(data_a), .grant_id(gid_a),
        .contention_count(cnt_a)
    );

    regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(4)) u_dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_address(req_address),
        .req_data(req_data), .req_ready(ready_b), .rf_write_enable(we_b),
        .rf_write_address(addr_b), .rf_write_data(data_b), .grant_id(gid_b),
        .contention_count(cnt_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_address[i*AW +: AW] = a;
        req_data[i*DW +: DW]    = d;
    endtask

    task automatic check_slot(input string tag, input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [1:0] g);
        check_eq({tag, "_we"},   64'(we_a), 64'(we));
        check_eq({tag, "_addr"}, 64'(addr_a), 64'(a));
        check_eq({tag, "_data"}, 64'(data_a), 64'(d));
        check_eq({tag, "_gid"},  64'(gid_a), 64'(g));
    endtask

    initial begin
        logic [2:0] exp_rdy;
        int         w;

        reset     = 1'b1;
        req_valid = 3'b111;
        set_req(0, 5'd1, 32'h1111_0001);
        set_req(1, 5'd2, 32'h2222_0002);
        set_req(2, 5'd3, 32'h3333_0003);

        // Reset held for two edges with all requesters valid
        tick();
        tick();
        check_eq("rst_ready", 64'(ready_a), 64'h0);
        check_eq("rst_ready_b", 64'(ready_b), 64'h0);
        check_slot("rst", 1'b0, 5'd0, 32'h0, 2'd0);
        check_eq("rst_cnt", 64'(cnt_a), 64'h0);
        check_eq("rst_cnt_b", 64'(cnt_b), 64'h0);

        reset     = 1'b0;
        req_valid = 3'b000;
        #1;
        check_eq("idle_ready", 64'(ready_a), 64'h0);
        tick();
        check_slot("idle", 1'b0, 5'd0, 32'h0, 2'd0);
        check_eq("idle_cnt", 64'(cnt_a), 64'h0);

        // Single load-unit request
        set_req(1, 5'd7, 32'hDEAD_BEEF);
        req_valid = 3'b010;
        #1;
        check_eq("single_ready", 64'(ready_a), 64'h2);
        tick();
        req_valid = 3'b000;
        check_slot("single", 1'b1, 5'd7, 32'hDEAD_BEEF, 2'd1);
        tick();
        check_slot("single_after", 1'b0, 5'd7, 32'hDEAD_BEEF, 2'd1);
        check_eq("single_cnt", 64'(cnt_a), 64'h0);

        // Round-robin over all three from a fresh pointer
        do_reset();
        set_req(0, 5'd1, 32'hA000_0000);
        set_req(1, 5'd2, 32'hB000_0001);
        set_req(2, 5'd3, 32'hC000_0002);
        req_valid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            w = i % 3;
            exp_rdy = 3'b001 << w;
            #1;
            check_eq($sformatf("rr_ready%0d", i), 64'(ready_a), 64'(exp_rdy));
            tick();
            check_eq($sformatf("rr_gid%0d", i), 64'(gid_a), 64'(w));
            check_eq($sformatf("rr_addr%0d", i), 64'(addr_a), 64'(w + 1));
            check_eq($sformatf("rr_we%0d", i), 64'(we_a), 64'h1);
        end
        req_valid = 3'b000;
        check_eq("rr_cnt", 64'(cnt_a), 64'd6);
        check_eq("rr_cnt_b", 64'(cnt_b), 64'd6);

        // Address-0 write from mul/div is accepted but dropped; pointer still moves
        set_req(0, 5'd5, 32'h0000_0055);
        req_valid = 3'b001;
        tick();
        check_slot("pre_x0", 1'b1, 5'd5, 32'h0000_0055, 2'd0);
        set_req(2, 5'd0, 32'h0000_1234);
        req_valid = 3'b100;
        #1;
        check_eq("x0_ready", 64'(ready_a), 64'h4);
        tick();
        check_slot("x0", 1'b0, 5'd0, 32'h0000_1234, 2'd2);
        req_valid = 3'b111;
        #1;
        check_eq("x0_next_ready", 64'(ready_a), 64'h1);
        tick();
        req_valid = 3'b000;
        check_eq("x0_next_gid", 64'(gid_a), 64'h0);
        check_eq("x0_cnt", 64'(cnt_a), 64'd7);

        // Saturation of the 4-bit counter under two-way contention
        do_reset();
        set_req(0, 5'd9, 32'h0000_0009);
        set_req(1, 5'd10, 32'h0000_000A);
        req_valid = 3'b011;
        for (int i = 0; i < 20; i++) begin
            exp_rdy = (i % 2 == 0) ? 3'b001 : 3'b010;
            #1;
            check_eq($sformatf("sat_ready%0d", i), 64'(ready_b), 64'(exp_rdy));
            tick();
            check_eq($sformatf("sat_gid%0d", i), 64'(gid_b), 64'(i % 2));
            check_eq($sformatf("sat_cnt_b%0d", i), 64'(cnt_b), 64'((i + 1 > 15) ? 15 : i + 1));
        end
        req_valid = 3'b000;
        check_eq("sat_cnt_a", 64'(cnt_a), 64'd20);
        check_eq("sat_cnt_b", 64'(cnt_b), 64'd15);

        // Reset arriving mid-stream
        do_reset();
        set_req(0, 5'd1, 32'h0000_0101);
        set_req(1, 5'd2, 32'h0000_0202);
        set_req(2, 5'd3, 32'h0000_0303);
        req_valid = 3'b111;
        tick();
        check_eq("mid_gid0", 64'(gid_a), 64'h0);
        tick();
        check_slot("mid_g1", 1'b1, 5'd2, 32'h0000_0202, 2'd1);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_ready", 64'(ready_a), 64'h0);
        tick();
        check_slot("mid_rst", 1'b0, 5'd0, 32'h0, 2'd0);
        check_eq("mid_rst_cnt", 64'(cnt_a), 64'h0);
        reset = 1'b0;
        #1;
        check_eq("mid_post_ready", 64'(ready_a), 64'h1);
        tick();
        req_valid = 3'b000;
        check_slot("mid_post", 1'b1, 5'd1, 32'h0000_0101, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port among three writeback requesters: ALU result, load unit, and multi-cycle multiply/divide unit. Each cycle it selects one requester by round-robin and registers the chosen address/data into a one-stage write slot that drives the register file write port. The registered slot also serves as a bypass source for operand forwarding. The block keeps a saturating count of contended cycles for performance monitoring.

## Interface
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register address width (32 registers; address 0 is hard-wired zero)
- CNT_WIDTH, 16, width of contention counter

- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high
- req_valid  input  3  per-requester write request; bit 0 ALU, bit 1 load, bit 2 muldiv
- req_address  input  3*ADDR_WIDTH  requester i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  input  3*DATA_WIDTH  requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  output  3  one-hot (or zero) grant; combinational from req_valid, priority pointer, reset
- rf_write_enable  output  1  registered; drives register file write_enable
- rf_write_address  output  ADDR_WIDTH  registered; drives register file write_address
- rf_write_data  output  DATA_WIDTH  registered; drives register file write_data
- grant_id  output  2  registered; index of requester whose write occupies the slot (0..2)
- contention_count  output  CNT_WIDTH  cycles with 2+ valid requesters; saturates at all-ones

## Operation
- Handshake: a transfer from requester i completes at a posedge where req_valid[i] and req_ready[i] are both 1. Requester holds valid/address/data stable until that edge. Arbiter does not depend on that.
- Priority pointer ptr (2 bits, values 0..2) names the highest-priority requester. Search order: ptr, ptr+1, ptr+2 (mod 3). The first valid requester wins; only its req_ready bit is 1.
- On any grant, ptr <= (winner+1) mod 3. With no valid requester, ptr is unchanged and no grant is made.
- On a grant to requester w with address A and data D, at the next edge: rf_write_address <= A, rf_write_data <= D, grant_id <= w, rf_write_enable <= (A != 0).
- Writes to address 0 are accepted (ready asserted, requester released) but dropped: rf_write_enable stays 0.
- With no grant: rf_write_enable <= 0; address/data/grant_id hold their previous values.
- contention_count increments by 1 at each edge where popcount(req_valid) >= 2 and reset is low. At all-ones it holds.
- Reset (sampled high at an edge): ptr <= 0, rf_write_enable <= 0, rf_write_address <= 0, rf_write_data <= 0, grant_id <= 0, contention_count <= 0. While reset is high, req_ready = 3'b000, so no handshake completes and any in-slot write is discarded.
- Illegal ptr value 3 (unreachable) is treated as 0.

## Timing
- Arbitration is combinational: req_ready settles within the cycle from req_valid and ptr. It never depends on req_address/req_data.
- Slot latency is 1 cycle. For a handshake at edge N, rf_write_enable is high during cycle N..N+1 and the register file captures the data at edge N+1.
- Throughput: one write accepted per cycle, sustained. A requester that is continuously valid is granted at least once every 3 cycles.
- The slot (rf_write_enable/address/data) is the forwarding source. A reader comparing its address with rf_write_address while rf_write_enable=1 uses rf_write_data.
- If reset rises in the same cycle as a valid request, the request is not granted; after reset falls, requester 0 has top priority.

## Test plan
- Reset then idle: hold reset 2 cycles with req_valid=3'b111. Required: req_ready=000, all outputs 0, contention_count=0. Release reset with req_valid=000: outputs unchanged.
- Single requester: req_valid=3'b010, address 7, data 0xDEADBEEF for one cycle. Required: req_ready=010 that cycle; next cycle rf_write_enable=1, address=7, data=0xDEADBEEF, grant_id=1; following cycle rf_write_enable=0.
- Round-robin fairness: req_valid=3'b111 held 6 cycles from reset. Required grant sequence 0,1,2,0,1,2; contention_count=6 afterward.
- x0 drop: requester 2 valid, address 0, data 0x1234. Required: req_ready=100, next cycle rf_write_enable=0, grant_id=2; ptr advances so requester 0 wins the next contended cycle.
- Contention saturation with CNT_WIDTH=4: req_valid=3'b011 for 20 cycles. Required: contention_count reaches 15 and holds; grants alternate 0,1.
- Reset mid-stream: req_valid=111 for 2 cycles (grants 0,1), then reset for 1 cycle, then release. Required: rf_write_enable=0 after the reset edge, and the first post-reset grant goes to requester 0.
